// File: rtl/i2c_slave_serial.sv
// -----------------------------------------------------------------------------
// i2c_slave_serial
//   Bit/byte-level I2C slave engine. Synchronises the raw SCL/SDA pads,
//   detects START/STOP, matches the 7-bit device address, generates ACKs and
//   converts bus traffic into register-interface accesses.
//
//   Write transfer : START, {addr,0}, reg pointer, data..., STOP
//   Read transfer  : START, {addr,1}, data... (master ACKs all but last byte)
//   The register pointer survives a repeated START, so the usual
//   "write pointer, Sr, read" sequence works.
//
// Parameters
//   I2C_ADDRESS    7-bit slave address compared with bits [7:1] of first byte
//   RESET_ADDR     register pointer value after reset
//
// Ports
//   clk            system clock (>= 16x SCL rate)
//   rst            synchronous active-high reset
//   sclIn, sdaIn   raw asynchronous pad inputs
//   sdaOut         0 = pull SDA low, 1 = release (open-drain pad is external)
//   regAddr        register pointer to the register interface
//   dataToRegIf    write data to the register interface
//   writeEn        one-clk write strobe, regAddr/dataToRegIf valid with it
//   dataFromRegIf  registered read data, valid 1 clk after regAddr changes
//   selected       high while this slave is addressed
//
// Optional feature
//   REG_ADDR_AUTOINC_EN : when defined, regAddr increments (mod 256) after
//   every ACKed write byte and every master-ACKed read byte. When undefined,
//   regAddr only changes through the register-pointer phase.
// -----------------------------------------------------------------------------
module i2c_slave_serial #(
    parameter logic [6:0] I2C_ADDRESS = 7'h3C,
    parameter logic [7:0] RESET_ADDR  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaOut,
    output logic [7:0] regAddr,
    output logic [7:0] dataToRegIf,
    output logic       writeEn,
    input  logic [7:0] dataFromRegIf,
    output logic       selected
);

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        REG_ADDR,
        ACK_REG,
        WR_DATA,
        ACK_WR,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchronisers plus one edge-detect stage per line.
    // Index 1 = SCL, index 0 = SDA. Everything resets to the idle-bus
    // level (high) so no spurious edge is seen coming out of reset.
    // ------------------------------------------------------------------
    logic [1:0] pad_in;
    logic [1:0] sync_val;
    logic [1:0] prev_val;

    assign pad_in = {sclIn, sdaIn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= pad_in[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign sync_val[gi] = sync_reg;
            assign prev_val[gi] = prev_reg;
        end
    endgenerate

    logic scl;
    logic sda;
    logic scl_prev;
    logic sda_prev;
    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    assign scl      = sync_val[1];
    assign sda      = sync_val[0];
    assign scl_prev = prev_val[1];
    assign sda_prev = prev_val[0];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    // SDA edges only count as bus conditions while SCL is steadily high.
    assign start_cond = scl & scl_prev & sda_prev & ~sda;
    assign stop_cond  = scl & scl_prev & ~sda_prev & sda;

    // ------------------------------------------------------------------
    // Byte engine
    // ------------------------------------------------------------------
    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       sda_out_reg;
    logic       sel_reg;
    logic [7:0] reg_addr_reg;
    logic [7:0] data_reg;
    logic       wr_en_reg;
    logic       rw_reg;
    // Set on the SCL rise of the ACK clock; the next fall ends the ACK slot.
    logic       ack_seen_reg;

    logic [7:0] rx_byte;
    logic [7:0] reg_addr_next;

    assign rx_byte = {shift_reg[6:0], sda};

`ifdef REG_ADDR_AUTOINC_EN
    assign reg_addr_next = reg_addr_reg + 8'd1;
`else
    assign reg_addr_next = reg_addr_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            sda_out_reg  <= 1'b1;
            sel_reg      <= 1'b0;
            reg_addr_reg <= RESET_ADDR;
            data_reg     <= 8'h00;
            wr_en_reg    <= 1'b0;
            rw_reg       <= 1'b0;
            ack_seen_reg <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;

            if (start_cond) begin
                // Any partial byte is simply dropped; regAddr is kept.
                state_reg   <= DEV_ADDR;
                bit_cnt_reg <= 3'd0;
                sda_out_reg <= 1'b1;
                sel_reg     <= 1'b0;
            end else if (stop_cond) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= 3'd0;
                sda_out_reg <= 1'b1;
                sel_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    DEV_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg  <= 3'd0;
                                ack_seen_reg <= 1'b0;
                                if (rx_byte[7:1] == I2C_ADDRESS) begin
                                    state_reg <= ACK_DEV;
                                    sel_reg   <= 1'b1;
                                    rw_reg    <= rx_byte[0];
                                end else begin
                                    state_reg <= WAIT_STOP;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end

                    ACK_DEV: begin
                        if (scl_fall) begin
                            if (!ack_seen_reg) begin
                                sda_out_reg <= 1'b0;
                            end else begin
                                bit_cnt_reg <= 3'd0;
                                if (rw_reg) begin
                                    // Present the first read byte's MSB now.
                                    shift_reg   <= dataFromRegIf;
                                    sda_out_reg <= dataFromRegIf[7];
                                    state_reg   <= RD_DATA;
                                end else begin
                                    sda_out_reg <= 1'b1;
                                    state_reg   <= REG_ADDR;
                                end
                            end
                        end else if (scl_rise) begin
                            ack_seen_reg <= 1'b1;
                        end
                    end

                    REG_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                reg_addr_reg <= rx_byte;
                                bit_cnt_reg  <= 3'd0;
                                ack_seen_reg <= 1'b0;
                                state_reg    <= ACK_REG;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end

                    ACK_REG: begin
                        if (scl_fall) begin
                            if (!ack_seen_reg) begin
                                sda_out_reg <= 1'b0;
                            end else begin
                                sda_out_reg <= 1'b1;
                                bit_cnt_reg <= 3'd0;
                                state_reg   <= WR_DATA;
                            end
                        end else if (scl_rise) begin
                            ack_seen_reg <= 1'b1;
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            if (bit_cnt_reg == 3'd7) begin
                                // Strobe appears the clk after the 8th bit,
                                // long before the pointer moves.
                                data_reg     <= rx_byte;
                                wr_en_reg    <= 1'b1;
                                bit_cnt_reg  <= 3'd0;
                                ack_seen_reg <= 1'b0;
                                state_reg    <= ACK_WR;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end

                    ACK_WR: begin
                        if (scl_fall) begin
                            if (!ack_seen_reg) begin
                                sda_out_reg <= 1'b0;
                            end else begin
                                sda_out_reg  <= 1'b1;
                                reg_addr_reg <= reg_addr_next;
                                bit_cnt_reg  <= 3'd0;
                                state_reg    <= WR_DATA;
                            end
                        end else if (scl_rise) begin
                            ack_seen_reg <= 1'b1;
                        end
                    end

                    RD_DATA: begin
                        if (scl_rise) begin
                            if (bit_cnt_reg == 3'd7) begin
                                bit_cnt_reg  <= 3'd0;
                                ack_seen_reg <= 1'b0;
                                state_reg    <= RD_ACK;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end else if (scl_fall) begin
                            sda_out_reg <= shift_reg[6];
                            shift_reg   <= {shift_reg[6:0], 1'b0};
                        end
                    end

                    RD_ACK: begin
                        if (scl_fall) begin
                            if (!ack_seen_reg) begin
                                // Release SDA for the master's ACK/NACK.
                                sda_out_reg <= 1'b1;
                            end else begin
                                // Pointer moved at the ACK rise, so the
                                // registered read data has already settled.
                                shift_reg   <= dataFromRegIf;
                                sda_out_reg <= dataFromRegIf[7];
                                bit_cnt_reg <= 3'd0;
                                state_reg   <= RD_DATA;
                            end
                        end else if (scl_rise) begin
                            if (!sda) begin
                                ack_seen_reg <= 1'b1;
                                reg_addr_reg <= reg_addr_next;
                            end else begin
                                sel_reg   <= 1'b0;
                                state_reg <= WAIT_STOP;
                            end
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP only leave on START/STOP.
                    end
                endcase
            end
        end
    end

    assign sdaOut      = sda_out_reg;
    assign regAddr     = reg_addr_reg;
    assign dataToRegIf = data_reg;
    assign writeEn     = wr_en_reg;
    assign selected    = sel_reg;

endmodule
